// File: rtl/seg7_display_ctrl_if.sv
// Load channel for seg7_display_ctrl: a binary value offered with valid/ready.
// A value transfers on a rising clk edge where load_valid and load_ready are both high.
interface seg7_display_ctrl_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value;
    logic               load_valid;
    logic               load_ready;

    modport master (
        output value,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  value,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// Multi-digit time-multiplexed 7-segment controller: double-dabble BCD conversion plus digit scan.
// Optional macro SEG7_LZ_BLANK_EN turns on leading-zero blanking.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seg7_display_ctrl_if.slave    load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [1:0]            dbg_state
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + VALUE_W;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SHC_W = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS);

    // One double-dabble iteration: correct every nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] a;
        a = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a[VALUE_W + 4*i +: 4] >= 4'd5)
                a[VALUE_W + 4*i +: 4] = a[VALUE_W + 4*i +: 4] + 4'd3;
        end
        return {a[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_e                  state_q, state_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic [SHC_W-1:0]        shc_q, shc_d;
    logic                    ovf_cap_q, ovf_cap_d;
    logic [BCD_W-1:0]        disp_bcd_q, disp_bcd_d;
    logic                    disp_ovf_q, disp_ovf_d;
    logic                    load_ready_q, load_ready_d;
    logic [CNT_W-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic [3:0]              cur_nib;
    logic                    lz_blank;
    logic [6:0]              digit_seg;

    // Conversion FSM
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        shc_d        = shc_q;
        ovf_cap_d    = ovf_cap_q;
        disp_bcd_d   = disp_bcd_q;
        disp_ovf_d   = disp_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load.load_valid && load_ready_q) begin
                    sr_d      = {{BCD_W{1'b0}}, load.value};
                    shc_d     = '0;
                    ovf_cap_d = (64'(load.value) >= OVF_LIMIT);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = dabble_step(sr_q);
                shc_d = shc_q + 1'b1;
                if (shc_q == SHC_W'(VALUE_W - 1))
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                disp_bcd_d = sr_q[SR_W-1 -: BCD_W];
                disp_ovf_d = ovf_cap_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        load_ready_d = (state_d == ST_IDLE);
    end

    // Digit scan; a tick always reads the display registers as they were before this edge.
    always_comb begin
        tick        = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
        cur_nib     = disp_bcd_q[{digit_idx_q, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
        begin
            logic                  run;
            logic [NUM_DIGITS-1:0] zero_above;
            run        = 1'b1;
            zero_above = '0;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                run           = run && (disp_bcd_q[4*i +: 4] == 4'd0);
                zero_above[i] = run;
            end
            lz_blank = zero_above[digit_idx_q] && (digit_idx_q != '0);
        end
`else
        lz_blank    = 1'b0;
`endif
        if (blank)
            digit_seg = 7'b1111111;
        else if (disp_ovf_q)
            digit_seg = 7'b1111110;
        else if (lz_blank)
            digit_seg = 7'b1111111;
        else
            digit_seg = seg_decode(cur_nib);

        seg_d       = seg_q;
        an_d        = an_q;
        digit_idx_d = digit_idx_q;
        if (tick) begin
            seg_d       = digit_seg;
            an_d        = ~(NUM_DIGITS'(1) << digit_idx_q);
            digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            shc_q        <= '0;
            ovf_cap_q    <= 1'b0;
            disp_bcd_q   <= '0;
            disp_ovf_q   <= 1'b0;
            load_ready_q <= 1'b1;
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            seg_q        <= 7'b1111111;
            an_q         <= '1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            shc_q        <= shc_d;
            ovf_cap_q    <= ovf_cap_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_ovf_q   <= disp_ovf_d;
            load_ready_q <= load_ready_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign load.load_ready = load_ready_q;
    assign seg             = seg_q;
    assign an              = an_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl with a decimal-arithmetic reference model.
// Load channel: a value transfers on a posedge where load_valid and load_ready are both high.
module tb_seg7_display_ctrl;
    localparam int ND = 4;
    localparam int VW = 14;
    localparam int SD = 4;
    localparam int W  = 7 + ND;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          blank = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc;
    int cur_v = 0;
    logic [W-1:0] exp_q[$];

    seg7_display_ctrl_if #(.VALUE_W(VW)) load_if ();

    seg7_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset_n(reset_n), .load(load_if), .blank(blank),
        .seg(seg), .an(an), .dbg_state(dbg_state)
    );

    // clock / reset-relative edge counter
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // reference model
    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int idx, input bit blk);
        if (blk) return 7'b1111111;
        if (v >= pow10(ND)) return 7'b1111110;
`ifdef SEG7_LZ_BLANK_EN
        if (idx > 0 && v < pow10(idx)) return 7'b1111111;
`endif
        return seg_of((v / pow10(idx)) % 10);
    endfunction

    function automatic logic [W-1:0] model_pair(input int v, input int idx, input bit blk);
        logic [ND-1:0] a;
        a = '1;
        a[idx] = 1'b0;
        return {model_seg(v, idx, blk), a};
    endfunction

    function automatic bit is_tick();
        return (cyc > 0) && (cyc % SD == 0);
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_next_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!is_tick() && n < 4 * SD);
        if (!is_tick()) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout cyc=%0d", cyc);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (load_if.load_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (load_if.load_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=%b required=1", load_if.load_ready);
        end
    endtask

    task automatic load_value(input int v, output int low_cycles);
        wait_ready();
        load_if.value      = VW'(v);
        load_if.load_valid = 1'b1;
        step();
        load_if.load_valid = 1'b0;
        low_cycles = 0;
        while (load_if.load_ready !== 1'b1 && low_cycles < 100) begin
            step();
            low_cycles++;
        end
        cur_v = v;
    endtask

    // scoreboard: one full rotation of seg/an pairs against the model
    task automatic check_display(input int v, input bit blk, input string name);
        int idx0;
        logic [W-1:0] got, exp;
        wait_next_tick();
        idx0 = (cyc / SD - 1) % ND;
        for (int k = 0; k < ND; k++) exp_q.push_back(model_pair(v, (idx0 + k) % ND, blk));
        for (int k = 0; k < ND; k++) begin
            if (k > 0) wait_next_tick();
            got = {seg, an};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s slot%0d seg/an got=%b/%b required=%b/%b",
                         name, k, got[W-1:ND], got[ND-1:0], exp[W-1:ND], exp[ND-1:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        step();
        checks++;
        if ({seg, an, load_if.load_ready} !== {7'b1111111, {ND{1'b1}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold seg=%b an=%b ready=%b required 1111111/1111/1", seg, an, load_if.load_ready);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e < SD) exp = {7'b1111111, {ND{1'b1}}};
            else        exp = model_pair(0, (e / SD - 1) % ND, 1'b0);
            checks++;
            if ({seg, an} !== exp) begin
                errors++;
                $display("FAIL reset_scan edge%0d got=%b/%b required=%b/%b", e, seg, an, exp[W-1:ND], exp[ND-1:0]);
            end
        end
    endtask

    task automatic test_load_basic();
        int low;
        load_value(1234, low);
        checks++;
        if (low !== VW + 1) begin
            errors++;
            $display("FAIL ready_low_cycles got=%0d required=%0d", low, VW + 1);
        end
        check_display(1234, 1'b0, "load_1234");
    endtask

    task automatic test_overflow();
        int low;
        load_value(10000, low);
        check_display(10000, 1'b0, "ovf_10000");
        load_value(16383, low);
        check_display(16383, 1'b0, "ovf_16383");
        load_value(9999, low);
        check_display(9999, 1'b0, "max_9999");
    endtask

    task automatic test_leading_zero();
        int low;
        load_value(7, low);
        check_display(7, 1'b0, "lz_7");
        load_value(0, low);
        check_display(0, 1'b0, "lz_0");
        load_value(305, low);
        check_display(305, 1'b0, "lz_305");
    endtask

    task automatic test_ignore_during_shift();
        int low = 0;
        wait_ready();
        load_if.value      = VW'(42);
        load_if.load_valid = 1'b1;
        step();
        load_if.value = VW'(99);
        for (int i = 0; i < 5; i++) begin
            step();
            low++;
        end
        load_if.load_valid = 1'b0;
        while (load_if.load_ready !== 1'b1 && low < 100) begin
            step();
            low++;
        end
        cur_v = 42;
        checks++;
        if (low !== VW + 1) begin
            errors++;
            $display("FAIL ignore_busy_len got=%0d required=%0d", low, VW + 1);
        end
        check_display(42, 1'b0, "ignore_99");
    endtask

    task automatic test_reset_mid_shift();
        wait_ready();
        load_if.value      = VW'(55);
        load_if.load_valid = 1'b1;
        step();
        load_if.load_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({seg, an, load_if.load_ready} !== {7'b1111111, {ND{1'b1}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_shift seg=%b an=%b ready=%b required 1111111/1111/1", seg, an, load_if.load_ready);
        end
        step();
        reset_n = 1'b1;
        cur_v = 0;
        step();
        checks++;
        if ({seg, an} !== {7'b1111111, {ND{1'b1}}}) begin
            errors++;
            $display("FAIL post_reset_dark seg=%b an=%b required 1111111/1111", seg, an);
        end
        check_display(0, 1'b0, "after_reset");
    endtask

    task automatic test_blank();
        blank = 1'b1;
        check_display(cur_v, 1'b1, "blank_on");
        blank = 1'b0;
        check_display(cur_v, 1'b0, "blank_off");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_ready();
        load_if.value      = VW'(321);
        load_if.load_valid = 1'b1;
        step();
        load_if.value = VW'(8765);
        do begin
            step();
            n++;
        end while (load_if.load_ready !== 1'b1 && n < 100);
        step();
        n++;
        load_if.load_valid = 1'b0;
        checks++;
        if (n !== VW + 2 || load_if.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back spacing=%0d ready=%b required %0d/0", n, load_if.load_ready, VW + 2);
        end
        wait_ready();
        cur_v = 8765;
        check_display(8765, 1'b0, "back_to_back");
    endtask

    task automatic test_random();
        int v, low;
        for (int i = 0; i < 8; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, (1 << VW) - 1));
            load_value(v, low);
            check_display(v, 1'b0, $sformatf("rand_%0d", v));
        end
    endtask

    initial begin
        load_if.value      = '0;
        load_if.load_valid = 1'b0;
        test_reset();
        test_load_basic();
        test_overflow();
        test_leading_zero();
        test_ignore_during_shift();
        test_reset_mid_shift();
        test_load_basic();
        test_blank();
        test_back_to_back();
        test_random();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover entries=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
